data_memory_unit: RTL

// - Data memory of the single-cycle RV32I core, directly downstream of the ALU: ALU_result drives addr.
// - Executes loads/stores sized by funct3 (byte/half/word), little-endian, sign/zero-extends load data.
// - Combinational read, synchronous write.
// - Flags misaligned/illegal accesses and latches the first faulting address for the trap logic.

---
 rtl/rv_mem_pkg.sv | 12 +
 rtl/data_memory_unit_if.sv | 26 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/data_memory_unit.sv | 87 ++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared RV32I memory-access definitions: data width and funct3 load/store encodings.
package rv_mem_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_memory_unit_if.sv
// Load/store bus between the core datapath (master) and the data memory (slave).
interface data_memory_unit_if;
    import rv_mem_pkg::*;

    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] read_data;
    logic              access_fault;
    logic              fault_valid;
    logic [DATA_W-1:0] fault_addr;
    logic              fault_clear;

    modport master (
        output addr, write_data, mem_read, mem_write, funct3, fault_clear,
        input  read_data, access_fault, fault_valid, fault_addr
    );

    modport slave (
        input  addr, write_data, mem_read, mem_write, funct3, fault_clear,
        output read_data, access_fault, fault_valid, fault_addr
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data
// and misaligned/illegal classification for one RV32I load/store.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        byte_off,
    input  logic              is_store,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_word,
    output logic [3:0]        byte_en,
    output logic [DATA_W-1:0] store_word,
    output logic [DATA_W-1:0] load_data,
    output logic              misaligned,
    output logic              illegal
);

    logic [15:0] lane_lo;

    always_comb begin
        // Bring the addressed lane down to bit 0; only 16 bits are ever needed.
        lane_lo    = 16'(load_word >> {byte_off, 3'b000});
        byte_en    = '0;
        store_word = '0;
        load_data  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << byte_off;
                store_word = {4{store_data[7:0]}};
                load_data  = {{24{lane_lo[7]}}, lane_lo[7:0]};
            end
            F3_BU: begin
                illegal    = is_store;
                load_data  = {24'd0, lane_lo[7:0]};
            end
            F3_H: begin
                misaligned = byte_off[0];
                byte_en    = 4'b0011 << byte_off;
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{lane_lo[15]}}, lane_lo};
            end
            F3_HU: begin
                misaligned = byte_off[0];
                illegal    = is_store;
                load_data  = {16'd0, lane_lo};
            end
            F3_W: begin
                misaligned = |byte_off;
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = load_word;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// RV32I data memory: combinational sized/extended reads, synchronous lane-masked writes,
// and a sticky first-fault address register for the trap logic.
module data_memory_unit
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_LSB    = 2
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_unit_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    logic              wr_en;

    logic [3:0]        byte_en;
    logic [DATA_W-1:0] store_word;
    logic [DATA_W-1:0] load_data;
    logic              misaligned;
    logic              illegal;
    logic              access_fault;

    logic              fault_valid_q, fault_valid_d;
    logic [DATA_W-1:0] fault_addr_q,  fault_addr_d;

    mem_lane_align u_align (
        .funct3     (bus.funct3),
        .byte_off   (bus.addr[1:0]),
        .is_store   (bus.mem_write),
        .store_data (bus.write_data),
        .load_word  (rd_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always_comb begin
        // Upper address bits are dropped, so accesses wrap around the array.
        word_idx     = bus.addr[ADDR_LSB +: IDX_W];
        rd_word      = mem_q[word_idx];
        access_fault = (bus.mem_read | bus.mem_write) & (misaligned | illegal);
        wr_en        = bus.mem_write & ~access_fault;
        for (int unsigned b = 0; b < 4; b++) begin
            wr_word[8*b +: 8] = byte_en[b] ? store_word[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        if (bus.fault_clear) begin
            fault_valid_d = 1'b0;
            fault_addr_d  = '0;
        end else if (access_fault && !fault_valid_q) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = bus.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q         <= '{default: '0};
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[word_idx] <= wr_word;
            end
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign bus.read_data    = (bus.mem_read && !access_fault) ? load_data : '0;
    assign bus.access_fault = access_fault;
    assign bus.fault_valid  = fault_valid_q;
    assign bus.fault_addr   = fault_addr_q;

endmodule
